// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared parameters and FSM state encoding for the register-file arbiter
package rf_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 3;
  localparam int DEPTH_DEF = 1 << AW_DEF;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/rf_bank.sv
// rtl/rf_bank.sv - DEPTH x DW register storage, one sync write port, one async read port
module rf_bank #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // Contents are not reset; zeroing is done by the owner's clear sequence.
  logic [DW-1:0] mem_q [DEPTH];

  // Synchronous write; written data is visible to the async read from the next cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - two-port round-robin access to a register bank with a clear sequence
module rf_port_arbiter
  import rf_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  input  logic          clr,
  output logic          busy
);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          ptr_q, ptr_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          grant_ok;
  logic          cnt_last;
  logic          bank_we;
  logic [AW-1:0] bank_waddr;
  logic [DW-1:0] bank_wdata;
  logic [AW-1:0] bank_raddr;
  logic [DW-1:0] bank_rdata;

  // Grants only while serving, out of reset, and not on the cycle a clear is requested.
  assign grant_ok = (state_q == SERVE) && reset && !clr;
  assign a_gnt    = grant_ok && a_req && (!b_req || !ptr_q);
  assign b_gnt    = grant_ok && b_req && (!a_req || ptr_q);
  assign cnt_last = (cnt_q == AW'(DEPTH - 1));

  assign busy     = (state_q == CLEAR);
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign rdata    = rdata_q;

  // Route the bank ports: clear sweep owns the write port, otherwise the granted side.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = a_addr;
    bank_wdata = a_wdata;
    bank_raddr = a_addr;
    if (state_q == CLEAR) begin
      bank_we    = reset;
      bank_waddr = cnt_q;
      bank_wdata = '0;
    end else if (a_gnt) begin
      bank_we    = a_we;
      bank_waddr = a_addr;
      bank_wdata = a_wdata;
      bank_raddr = a_addr;
    end else if (b_gnt) begin
      bank_we    = b_we;
      bank_waddr = b_addr;
      bank_wdata = b_wdata;
      bank_raddr = b_addr;
    end
  end

  // Next pointer and read-return values derived from this cycle's grant.
  always_comb begin
    ptr_d      = ptr_q;
    a_rvalid_d = a_gnt && !a_we;
    b_rvalid_d = b_gnt && !b_we;
    rdata_d    = rdata_q;
    if (a_gnt) begin
      ptr_d = 1'b1;
    end else if (b_gnt) begin
      ptr_d = 1'b0;
    end
    if (a_rvalid_d || b_rvalid_d) begin
      rdata_d = bank_rdata;
    end
  end

  // Serve/clear FSM with the clear counter, round-robin pointer and read-return registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      ptr_q      <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      rdata_q    <= rdata_d;
      case (state_q)
        SERVE: begin
          if (clr) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (cnt_last) begin
            state_q <= SERVE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  rf_bank #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk     (clk),
    .we_i    (bank_we),
    .waddr_i (bank_waddr),
    .wdata_i (bank_wdata),
    .raddr_i (bank_raddr),
    .rdata_o (bank_rdata)
  );

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb/tb_rf_port_arbiter.sv - self-checking bench for rf_port_arbiter
module tb_rf_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we, clr;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
  logic [7:0] rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       a_req, a_we;
    logic [2:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req, b_we;
    logic [2:0] b_addr;
    logic [7:0] b_wdata;
    logic       clr;
    logic       ea, eb, ebusy;
  } vec_t;

  typedef struct {
    logic       a, b;
    logic [7:0] data;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sbq[$];
  logic [7:0] mem_m [8];
  logic [7:0] last_rdata;

  rf_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .rdata    (rdata),
    .clr      (clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic ar, aw, input logic [2:0] aa, input logic [7:0] ad,
                              input logic br, bw, input logic [2:0] ba, input logic [7:0] bd,
                              input logic c, ea, eb, ebusy);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.clr = c; v.ea = ea; v.eb = eb; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic check_rd(input string tag);
    sb_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_a_rvalid"}, a_rvalid, e.a);
      chk({tag, "_b_rvalid"}, b_rvalid, e.b);
      chk({tag, "_rdata"}, rdata, e.data);
      last_rdata = e.data;
    end else begin
      chk({tag, "_a_rvalid_idle"}, a_rvalid, 0);
      chk({tag, "_b_rvalid_idle"}, b_rvalid, 0);
      chk({tag, "_rdata_hold"}, rdata, last_rdata);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
    clr = v.clr;
    #1;
    chk({tag, "_a_gnt"}, a_gnt, v.ea);
    chk({tag, "_b_gnt"}, b_gnt, v.eb);
    chk({tag, "_busy"}, busy, v.ebusy);
    chk({tag, "_gnt_excl"}, a_gnt & b_gnt, 0);
    if (v.ea && !v.a_we) begin
      e.a = 1'b1; e.b = 1'b0; e.data = mem_m[v.a_addr];
      sbq.push_back(e);
    end
    if (v.eb && !v.b_we) begin
      e.a = 1'b0; e.b = 1'b1; e.data = mem_m[v.b_addr];
      sbq.push_back(e);
    end
    if (v.ea && v.a_we) mem_m[v.a_addr] = v.a_wdata;
    if (v.eb && v.b_we) mem_m[v.b_addr] = v.b_wdata;
    if (v.clr && !v.ebusy) begin
      for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    end
    @(posedge clk); #1;
    check_rd(tag);
  endtask

  task automatic count_busy(input int clr_at, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      clr = (n == clr_at);
      chk("clear_a_gnt", a_gnt, 0);
      chk("clear_b_gnt", b_gnt, 0);
      chk("clear_rvalid", {a_rvalid, b_rvalid}, 0);
      n++;
      @(posedge clk); #1;
    end
    clr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    clr = 0;
    sbq.delete();
    last_rdata = 8'h00;
    repeat (n) begin
      @(posedge clk); #1;
    end
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;

    vecs.push_back(mk(1,0,3'd5,8'h00, 0,0,3'd0,8'h00, 0, 1,0,0));
    vecs.push_back(mk(1,1,3'd2,8'h3C, 0,0,3'd0,8'h00, 0, 1,0,0));
    vecs.push_back(mk(0,0,3'd0,8'h00, 1,0,3'd2,8'h00, 0, 0,1,0));
    vecs.push_back(mk(0,0,3'd0,8'h00, 0,0,3'd0,8'h00, 0, 0,0,0));
    vecs.push_back(mk(1,1,3'd1,8'h11, 1,0,3'd1,8'h00, 0, 1,0,0));
    vecs.push_back(mk(1,1,3'd2,8'h22, 1,0,3'd1,8'h00, 0, 0,1,0));
    vecs.push_back(mk(1,1,3'd2,8'h22, 1,0,3'd2,8'h00, 0, 1,0,0));
    vecs.push_back(mk(1,1,3'd3,8'h33, 1,0,3'd2,8'h00, 0, 0,1,0));
    vecs.push_back(mk(1,1,3'd3,8'h33, 1,0,3'd3,8'h00, 0, 1,0,0));
    vecs.push_back(mk(1,0,3'd3,8'h00, 1,0,3'd3,8'h00, 0, 0,1,0));
    vecs.push_back(mk(0,0,3'd0,8'h00, 1,0,3'd7,8'h00, 0, 0,1,0));
    vecs.push_back(mk(1,0,3'd2,8'h00, 1,0,3'd1,8'h00, 0, 1,0,0));
    vecs.push_back(mk(1,0,3'd7,8'h00, 1,1,3'd7,8'hA5, 0, 0,1,0));
    vecs.push_back(mk(1,0,3'd7,8'h00, 0,0,3'd0,8'h00, 0, 1,0,0));
    vecs.push_back(mk(0,0,3'd0,8'h00, 0,0,3'd0,8'h00, 0, 0,0,0));

    do_reset(2);
    count_busy(-1, n);
    chk("post_reset_busy_cycles", n, 8);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // clr while both request: no grant, full sweep, pointer kept on B
    apply(mk(1,0,3'd0,8'h00, 1,0,3'd1,8'h00, 1, 0,0,0), "clr_both");
    count_busy(-1, n);
    chk("clr_busy_cycles", n, 8);
    apply(mk(1,0,3'd0,8'h00, 1,0,3'd1,8'h00, 0, 0,1,0), "ptr_kept");
    for (int i = 0; i < 8; i++)
      apply(mk(1,0,3'(i),8'h00, 0,0,3'd0,8'h00, 0, 1,0,0), $sformatf("readback%0d", i));

    // clr re-pulsed mid-sweep does not restart the counter
    apply(mk(0,0,3'd0,8'h00, 0,0,3'd0,8'h00, 1, 0,0,0), "clr_again");
    count_busy(4, n);
    chk("clr_repulse_busy_cycles", n, 8);

    // reset right after an A read grant drops the pending return
    apply(mk(1,1,3'd5,8'h77, 0,0,3'd0,8'h00, 0, 1,0,0), "wr5");
    apply(mk(1,0,3'd5,8'h00, 0,0,3'd0,8'h00, 0, 1,0,0), "rd5");
    a_req = 1'b1;
    reset = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("rst_mid_read_a_rvalid", a_rvalid, 0);
    chk("rst_mid_read_rdata", rdata, 0);
    chk("rst_mid_read_busy", busy, 1);
    last_rdata = 8'h00;
    reset = 1'b1;
    count_busy(-1, n);
    chk("rst_mid_read_busy_cycles", n, 8);
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    apply(mk(1,0,3'd5,8'h00, 0,0,3'd0,8'h00, 0, 1,0,0), "rd5_cleared");

    // reset in the middle of the sweep restarts it from zero
    do_reset(1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    do_reset(1);
    count_busy(-1, n);
    chk("rst_mid_clear_busy_cycles", n, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  DW, 8, data width.
  AW, 3, address width.
  DEPTH, 8, register count (2**AW).
REQ-002 Ports SHALL be, one per line:
  clk  input  1  sole clock, rising edge.
  reset  input  1  synchronous, active-low reset.
  a_req  input  1  requester A access request; held until a_gnt.
  a_we  input  1  A access type: 1 write, 0 read.
  a_addr  input  AW  A register address.
  a_wdata  input  DW  A write data.
  a_gnt  output  1  A granted this cycle (combinational).
  a_rvalid  output  1  rdata holds A read result (registered).
  b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid  same as A, for requester B.
  rdata  output  DW  shared read data, qualified by a_rvalid/b_rvalid.
  clr  input  1  single-cycle request to zero all registers.
  busy  output  1  clear sequence in progress; no grants.
REQ-003 Clock and reset SHALL be exactly as stated: one clock, clk; reset synchronous, active-low.

Function
REQ-004 The FSM SHALL have two states: SERVE and CLEAR.
REQ-005 In SERVE, at most one grant per cycle; a_gnt and b_gnt never both 1.
REQ-006 Arbitration SHALL be round-robin via a 1-bit pointer ptr (0=A, 1=B): if both request, grant the ptr side; if only one requests, grant it.
REQ-007 After any grant, ptr SHALL point to the non-granted side on the next edge; with no grant, ptr holds.
REQ-008 A granted write SHALL update storage at the edge ending the grant cycle.
REQ-009 A granted read SHALL drive rdata with the addressed contents and raise that side's rvalid for exactly one cycle, on the cycle after the grant (latency 1).
REQ-010 rvalid outputs SHALL be 0 when no read was granted in the previous cycle; rdata SHALL hold its last value.
REQ-011 A read granted in the cycle after a write to the same address SHALL return the newly written data.
REQ-012 clr=1 in SERVE SHALL suppress all grants that cycle and enter CLEAR on the next edge.
REQ-013 In CLEAR, a 3-bit counter SHALL step 0..DEPTH-1, writing 0 to register[counter] each cycle; busy=1; both gnt=0.
REQ-014 After writing DEPTH-1, the FSM SHALL return to SERVE on the next edge; ptr unchanged through CLEAR.
REQ-015 clr asserted during CLEAR SHALL be ignored; the counter does not restart.
REQ-016 Requests during CLEAR SHALL be held by the requester and serviced per REQ-006 from the first SERVE cycle.
REQ-017 busy SHALL be 1 exactly during CLEAR.

Reset
REQ-018 While reset=0 at a clk edge: state<=CLEAR, counter<=0, ptr<=0, a_rvalid<=0, b_rvalid<=0, rdata<=0.
REQ-019 Storage SHALL be zeroed only by the CLEAR sequence: after reset releases, busy=1 for DEPTH cycles.
REQ-020 Reset mid-read SHALL drop any pending rvalid; reset mid-CLEAR SHALL restart the counter at 0.

Structure
REQ-021 Parameter defaults and the state encoding (SERVE, CLEAR) SHALL reside in a shared package rf_pkg.
REQ-022 Storage SHALL be one sub-module, rf_bank: DEPTH x DW, one synchronous write port, one asynchronous read port, no reset.
REQ-023 Arbiter, FSM, counter and read register SHALL live in rf_port_arbiter; target 150-300 lines total.

Verification
REQ-024 Reset held 2 cycles, then released -> busy=1 for exactly 8 cycles; then A reads addr 5 -> a_rvalid next cycle with rdata=0x00.
REQ-025 A writes 0x3C to addr 2; next cycle B reads addr 2 -> b_gnt=1, then b_rvalid=1 with rdata=0x3C, a_rvalid=0.
REQ-026 A and B request continuously for 6 cycles with ptr=0 -> grants alternate A,B,A,B,A,B; never both high.
REQ-027 clr pulsed while both request -> no grant that cycle; busy=1 for 8 cycles; all 8 registers read back 0x00; ptr preserved.
REQ-028 clr pulsed again at CLEAR counter=4 -> CLEAR still ends after counter=7 (8 cycles total).
REQ-029 Reset asserted the cycle after an A read grant -> a_rvalid stays 0, busy=1 after release.
